// File: rtl/qpu_exu_dec_stage_if.sv
// Handshake bundle for the QPU decode stage: upstream instruction feed plus downstream decoded issue.
// The o_ilgl signal exists only when QPU_DEC_ILGL_CHK_EN is defined.
interface qpu_exu_dec_stage_if #(
   parameter int PC_W = 32
);
   logic            i_valid;
   logic            i_ready;
   logic [31:0]     i_instr;
   logic [PC_W-1:0] i_pc;
   logic            i_prdt_taken;

   logic            o_valid;
   logic            o_ready;
   logic [31:0]     o_instr;
   logic [PC_W-1:0] o_pc;
   logic            o_prdt_taken;
   logic [1:0]      o_grp;
   logic            o_new_timepoint;
   logic            o_measure;
   logic            o_fmr;
   logic [2:0]      o_qpi;
`ifdef QPU_DEC_ILGL_CHK_EN
   logic            o_ilgl;

   modport master (
      output i_valid, i_instr, i_pc, i_prdt_taken, o_ready,
      input  i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_grp,
             o_new_timepoint, o_measure, o_fmr, o_qpi, o_ilgl
   );

   modport slave (
      input  i_valid, i_instr, i_pc, i_prdt_taken, o_ready,
      output i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_grp,
             o_new_timepoint, o_measure, o_fmr, o_qpi, o_ilgl
   );
`else
   modport master (
      output i_valid, i_instr, i_pc, i_prdt_taken, o_ready,
      input  i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_grp,
             o_new_timepoint, o_measure, o_fmr, o_qpi
   );

   modport slave (
      input  i_valid, i_instr, i_pc, i_prdt_taken, o_ready,
      output i_ready, o_valid, o_instr, o_pc, o_prdt_taken, o_grp,
             o_new_timepoint, o_measure, o_fmr, o_qpi
   );
`endif
endinterface

// File: rtl/qpu_exu_dec_stage.sv
// QPU execute-unit decode stage: decodes at enqueue into a small FIFO and gates issue on measurement state.
// Define QPU_DEC_ILGL_CHK_EN to add illegal-opcode detection (o_ilgl).
module qpu_exu_dec_stage #(
   parameter int  PC_W       = 32,
   parameter int  FIFO_DEPTH = 2,
   parameter int  MEAS_MAX   = 7,
   localparam int CW         = $clog2(MEAS_MAX + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               meas_done,
   output logic [CW-1:0]      meas_pend,
   qpu_exu_dec_stage_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00010;
   localparam logic [4:0] OPC_OP     = 5'b01010;
   localparam logic [4:0] OPC_QWAIT  = 5'b10010;
   localparam logic [4:0] OPC_FMR    = 5'b11010;
   localparam logic [4:0] OPC_SMIS   = 5'b00110;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            prdt;
      logic [1:0]      grp;
      logic            ntp;
      logic            meas;
      logic            fmr;
      logic [2:0]      qpi;
`ifdef QPU_DEC_ILGL_CHK_EN
      logic            ilgl;
`endif
   } entry_t;

   entry_t          mem [FIFO_DEPTH];
   entry_t          dec_entry;
   entry_t          shown;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [NW-1:0]   count;
   logic            full;
   logic            empty;
   logic            hold;
   logic            push;
   logic            pop;
   logic            meas_inc;
   logic            meas_dec;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Decode happens on the way in so the issue side only ever reads registered fields.
   always_comb begin
      dec_entry       = '0;
      dec_entry.instr = bus.i_instr;
      dec_entry.pc    = bus.i_pc;
      dec_entry.prdt  = bus.i_prdt_taken;
      if (bus.i_instr[0]) begin
         dec_entry.grp  = 2'b11;
         dec_entry.qpi  = bus.i_instr[31:29];
         dec_entry.ntp  = |bus.i_instr[31:29];
         dec_entry.meas = (bus.i_instr[9:1] == 9'h0FF);
      end else begin
         case (bus.i_instr[4:0])
            OPC_LOAD, OPC_STORE:        dec_entry.grp = 2'b01;
            OPC_BRANCH:                 dec_entry.grp = 2'b10;
            OPC_QWAIT:                  dec_entry.ntp = 1'b1;
            OPC_FMR:                    dec_entry.fmr = 1'b1;
            OPC_OPIMM, OPC_OP, OPC_SMIS: dec_entry.grp = 2'b00;
            default: begin
`ifdef QPU_DEC_ILGL_CHK_EN
               dec_entry.ilgl = 1'b1;
`endif
            end
         endcase
      end
   end

   assign full  = (count == NW'(FIFO_DEPTH));
   assign empty = (count == '0);

   always_comb begin
      shown = '0;
      if (!empty) begin
         shown = mem[rd_ptr];
      end
   end

   // An fmr must wait for every measurement to return; a measure must wait for a free slot.
   assign hold = (shown.fmr && (meas_pend != '0)) ||
                 (shown.meas && (meas_pend == CW'(MEAS_MAX)));

   assign bus.i_ready         = ~full & ~rst;
   assign bus.o_valid         = ~empty & ~hold;
   assign bus.o_instr         = shown.instr;
   assign bus.o_pc            = shown.pc;
   assign bus.o_prdt_taken    = shown.prdt;
   assign bus.o_grp           = shown.grp;
   assign bus.o_new_timepoint = shown.ntp;
   assign bus.o_measure       = shown.meas;
   assign bus.o_fmr           = shown.fmr;
   assign bus.o_qpi           = shown.qpi;
`ifdef QPU_DEC_ILGL_CHK_EN
   assign bus.o_ilgl          = shown.ilgl;
`endif

   assign push     = bus.i_valid & bus.i_ready;
   assign pop      = bus.o_valid & bus.o_ready;
   assign meas_inc = pop & shown.meas;
   assign meas_dec = meas_done & (meas_pend != '0);

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= dec_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + NW'(1);
         end else if (pop && !push) begin
            count <= count - NW'(1);
         end
      end
   end

   // Outstanding measurements survive a flush: results still come back from the QPU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meas_pend <= '0;
      end else if (meas_inc && !meas_dec) begin
         meas_pend <= meas_pend + CW'(1);
      end else if (meas_dec && !meas_inc) begin
         meas_pend <= meas_pend - CW'(1);
      end
   end

endmodule

// File: tb/tb_qpu_exu_dec_stage.sv
// Randomized self-checking bench for qpu_exu_dec_stage against a queue-based reference model.
// Build with QPU_DEC_ILGL_CHK_EN defined to also exercise o_ilgl.
module tb_qpu_exu_dec_stage;

   localparam int PC_W       = 32;
   localparam int FIFO_DEPTH = 2;
   localparam int MEAS_MAX   = 7;
   localparam int CW         = $clog2(MEAS_MAX + 1);
`ifdef QPU_DEC_ILGL_CHK_EN
   localparam bit ILGL_EN = 1'b1;
`else
   localparam bit ILGL_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic            prdt;
   } item_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          meas_done = 1'b0;
   logic [CW-1:0] meas_pend;

   item_t model_q[$];
   int    model_pend = 0;
   int    checks = 0;
   int    failures = 0;

   qpu_exu_dec_stage_if #(.PC_W(PC_W)) bus ();

   qpu_exu_dec_stage #(
      .PC_W(PC_W), .FIFO_DEPTH(FIFO_DEPTH), .MEAS_MAX(MEAS_MAX)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .meas_done(meas_done),
      .meas_pend(meas_pend), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference decode written straight from the opcode table.
   function automatic void refDecode(input logic [31:0] ins, output int grp, output bit ntp,
                                     output bit meas, output bit fmr, output int qpi, output bit ilgl);
      grp = 0; ntp = 0; meas = 0; fmr = 0; qpi = 0; ilgl = 0;
      if (ins[0]) begin
         grp  = 3;
         qpi  = int'(ins[31:29]);
         ntp  = (qpi != 0);
         meas = (ins[9:1] == 9'h0FF);
      end else begin
         case (ins[4:0])
            5'b00000, 5'b01000: grp = 1;
            5'b11000: grp = 2;
            5'b10010: ntp = 1;
            5'b11010: fmr = 1;
            5'b00010, 5'b01010, 5'b00110: grp = 0;
            default: ilgl = ILGL_EN;
         endcase
      end
   endfunction

   function automatic bit modelValid();
      int grp, qpi;
      bit ntp, meas, fmr, ilgl;
      if (model_q.size() == 0) return 1'b0;
      refDecode(model_q[0].instr, grp, ntp, meas, fmr, qpi, ilgl);
      if (fmr && model_pend != 0) return 1'b0;
      if (meas && model_pend == MEAS_MAX) return 1'b0;
      return 1'b1;
   endfunction

   task automatic compareAll();
      int grp, qpi;
      bit ntp, meas, fmr, ilgl;
      checkOutput("i_ready", bus.i_ready, (model_q.size() < FIFO_DEPTH));
      checkOutput("o_valid", bus.o_valid, modelValid());
      checkOutput("meas_pend", meas_pend, model_pend);
      if (model_q.size() > 0) begin
         refDecode(model_q[0].instr, grp, ntp, meas, fmr, qpi, ilgl);
         checkOutput("o_instr", bus.o_instr, model_q[0].instr);
         checkOutput("o_pc", bus.o_pc, model_q[0].pc);
         checkOutput("o_prdt_taken", bus.o_prdt_taken, model_q[0].prdt);
         checkOutput("o_grp", bus.o_grp, grp);
         checkOutput("o_new_timepoint", bus.o_new_timepoint, ntp);
         checkOutput("o_measure", bus.o_measure, meas);
         checkOutput("o_fmr", bus.o_fmr, fmr);
         checkOutput("o_qpi", bus.o_qpi, qpi);
`ifdef QPU_DEC_ILGL_CHK_EN
         checkOutput("o_ilgl", bus.o_ilgl, ilgl);
`endif
      end
   endtask

   // One clock: drive inputs, compare, then advance the model across the edge.
   task automatic applyStimulus(input bit iv, input logic [31:0] instr, input logic [PC_W-1:0] pc,
                                input bit prdt, input bit ordy, input bit fl, input bit md);
      bit push, pop, inc, dec;
      int grp, qpi;
      bit ntp, meas, fmr, ilgl;
      item_t it;
      bus.i_valid      = iv;
      bus.i_instr      = instr;
      bus.i_pc         = pc;
      bus.i_prdt_taken = prdt;
      bus.o_ready      = ordy;
      flush            = fl;
      meas_done        = md;
      #1;
      compareAll();
      push = iv && (model_q.size() < FIFO_DEPTH);
      pop  = modelValid() && ordy;
      meas = 1'b0;
      if (model_q.size() > 0) refDecode(model_q[0].instr, grp, ntp, meas, fmr, qpi, ilgl);
      inc = pop && meas;
      dec = md && (model_pend > 0);
      @(posedge clk);
      model_pend = model_pend + int'(inc) - int'(dec);
      if (fl) begin
         model_q.delete();
      end else begin
         if (pop) void'(model_q.pop_front());
         if (push) begin
            it.instr = instr; it.pc = pc; it.prdt = prdt;
            model_q.push_back(it);
         end
      end
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_i_ready"}, bus.i_ready, 0);
      checkOutput({tag, "_o_valid"}, bus.o_valid, 0);
      checkOutput({tag, "_meas_pend"}, meas_pend, 0);
      checkOutput({tag, "_o_instr"}, bus.o_instr, 0);
      checkOutput({tag, "_o_pc"}, bus.o_pc, 0);
      checkOutput({tag, "_o_grp"}, bus.o_grp, 0);
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 11))
         0: r[4:0] = 5'b00000;
         1: r[4:0] = 5'b01000;
         2: r[4:0] = 5'b11000;
         3: r[4:0] = 5'b00010;
         4: r[4:0] = 5'b01010;
         5: r[4:0] = 5'b10010;
         6: r[4:0] = 5'b11010;
         7: r[4:0] = 5'b00110;
         8: r[0] = 1'b1;
         9, 10: r[9:0] = 10'h1FF;
         default: r = r;
      endcase
      return r;
   endfunction

   task automatic randomCycles(input int n);
      bit ordy, md;
      for (int i = 0; i < n; i++) begin
         ordy = ($urandom_range(0, 3) != 0);
         md   = ($urandom_range(0, 5) == 0);
         if (model_pend == 0 && ordy) md = 1'b0;
         applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom, 1'($urandom),
                       ordy, $urandom_range(0, 31) == 0, md);
      end
   endtask

   initial begin
      bus.i_valid = 0; bus.i_instr = '0; bus.i_pc = '0; bus.i_prdt_taken = 0; bus.o_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      rst = 1'b0;

      // Plain op-imm at PC 0x10.
      applyStimulus(1, 32'h0000_0002, 32'h10, 0, 0, 0, 0);
      checkOutput("req034_valid", bus.o_valid, 1);
      checkOutput("req034_grp", bus.o_grp, 0);
      checkOutput("req034_pc", bus.o_pc, 32'h10);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);

      // Quantum instruction with a nonzero pre-interval.
      applyStimulus(1, 32'h6000_0001, 32'h14, 1, 0, 0, 0);
      checkOutput("req035_grp", bus.o_grp, 3);
      checkOutput("req035_qpi", bus.o_qpi, 3);
      checkOutput("req035_ntp", bus.o_new_timepoint, 1);
      checkOutput("req035_meas", bus.o_measure, 0);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);

      // Measure then fmr: fmr waits for the result.
      applyStimulus(1, 32'h0000_01FF, 32'h18, 0, 1, 0, 0);
      applyStimulus(1, 32'h0000_001A, 32'h1C, 0, 1, 0, 0);
      checkOutput("req036_pend", meas_pend, 1);
      checkOutput("req036_held", bus.o_valid, 0);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);
      applyStimulus(0, '0, '0, 0, 1, 0, 1);
      checkOutput("req036_release", bus.o_valid, 1);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);
      checkOutput("req036_empty", bus.o_valid, 0);

      // Fill with o_ready low, then drain in order.
      for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(1, 32'h100 + 32'(i << 8), 32'h40 + 32'(i), 0, 0, 0, 0);
      checkOutput("req037_full", bus.i_ready, 0);
      applyStimulus(1, 32'h0000_0033, 32'h50, 0, 0, 0, 0);
      for (int i = 0; i <= FIFO_DEPTH; i++) applyStimulus(0, '0, '0, 0, 1, 0, 0);
      checkOutput("req037_ready_back", bus.i_ready, 1);

      // meas_done at zero is ignored.
      applyStimulus(0, '0, '0, 0, 0, 0, 1);
      checkOutput("pend_no_underflow", meas_pend, 0);

      // Saturate outstanding measurements, then flush with entries buffered.
      for (int i = 0; i < MEAS_MAX + 1; i++) applyStimulus(1, 32'h0000_01FF | 32'(i << 29), 32'h80 + 32'(i), 0, 1, 0, 0);
      checkOutput("req038_sat", meas_pend, MEAS_MAX);
      checkOutput("req038_held", bus.o_valid, 0);
      applyStimulus(0, '0, '0, 0, 1, 0, 1);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);
      checkOutput("req038_pend_max", meas_pend, MEAS_MAX);
      applyStimulus(1, 32'h0000_0002, 32'hA0, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0033, 32'hA4, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0013, 32'hA8, 0, 1, 1, 0);
      checkOutput("req038_flush_valid", bus.o_valid, 0);
      checkOutput("req038_flush_pend", meas_pend, MEAS_MAX);
      for (int i = 0; i < MEAS_MAX; i++) applyStimulus(0, '0, '0, 0, 0, 0, 1);

`ifdef QPU_DEC_ILGL_CHK_EN
      applyStimulus(1, 32'h0000_0004, 32'hC0, 0, 0, 0, 0);
      checkOutput("req039_ilgl", bus.o_ilgl, 1);
      checkOutput("req039_grp", bus.o_grp, 0);
      applyStimulus(0, '0, '0, 0, 1, 0, 0);
`endif

      randomCycles(2000);

      // Reset in the middle of traffic clears everything at once.
      applyStimulus(1, 32'h0000_01FF, 32'hE0, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0008, 32'hE4, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      checkResetState("midreset");
      model_q.delete();
      model_pend = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_i_ready", bus.i_ready, 1);
      randomCycles(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
